// File: rtl/leglite_pkg.sv
// Shared constants and enumerations for the LEGLite multicycle control path.
package leglite_pkg;

    // Opcode map
    localparam int unsigned OP_ADD  = 0;
    localparam int unsigned OP_SUB  = 1;
    localparam int unsigned OP_SLT  = 2;
    localparam int unsigned OP_LW   = 3;
    localparam int unsigned OP_SW   = 4;
    localparam int unsigned OP_BEQ  = 5;
    localparam int unsigned OP_ADDI = 6;
    localparam int unsigned OP_ANDI = 7;

    // ALU select encodings
    localparam int unsigned ALU_ADD = 0;
    localparam int unsigned ALU_SUB = 1;
    localparam int unsigned ALU_SLT = 2;
    localparam int unsigned ALU_AND = 3;

    // Controller sequencing states
    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB
    } ctl_state_t;

    // Instruction classes that steer the state sequence
    typedef enum logic [2:0] {
        CLS_R,
        CLS_LW,
        CLS_SW,
        CLS_BEQ,
        CLS_IMM,
        CLS_ILL
    } instr_class_t;

endpackage

// File: rtl/control_decode.sv
// Combinational opcode decode: instruction class plus per-class datapath fields.
module control_decode
    import leglite_pkg::*;
#(
    parameter int unsigned OPCODE_W  = 3,
    parameter int unsigned ALU_SEL_W = 3
) (
    input  logic [OPCODE_W-1:0]  op_i,
    output instr_class_t         cls_o,
    output logic [ALU_SEL_W-1:0] alu_select_o,
    output logic                 alusrc_o,
    output logic                 regdst_o,
    output logic                 memtoreg_o
);

    // Opcode to class/field lookup; anything unmapped is illegal
    always_comb begin
        cls_o        = CLS_ILL;
        alu_select_o = ALU_SEL_W'(ALU_ADD);
        alusrc_o     = 1'b0;
        regdst_o     = 1'b0;
        memtoreg_o   = 1'b0;
        case (op_i)
            OPCODE_W'(OP_ADD): begin
                cls_o    = CLS_R;
                regdst_o = 1'b1;
            end
            OPCODE_W'(OP_SUB): begin
                cls_o        = CLS_R;
                regdst_o     = 1'b1;
                alu_select_o = ALU_SEL_W'(ALU_SUB);
            end
            OPCODE_W'(OP_SLT): begin
                cls_o        = CLS_R;
                regdst_o     = 1'b1;
                alu_select_o = ALU_SEL_W'(ALU_SLT);
            end
            OPCODE_W'(OP_LW): begin
                cls_o      = CLS_LW;
                alusrc_o   = 1'b1;
                memtoreg_o = 1'b1;
            end
            OPCODE_W'(OP_SW): begin
                cls_o    = CLS_SW;
                alusrc_o = 1'b1;
            end
            OPCODE_W'(OP_BEQ): begin
                cls_o        = CLS_BEQ;
                alu_select_o = ALU_SEL_W'(ALU_SUB);
            end
            OPCODE_W'(OP_ADDI): begin
                cls_o    = CLS_IMM;
                alusrc_o = 1'b1;
            end
            OPCODE_W'(OP_ANDI): begin
                cls_o        = CLS_IMM;
                alusrc_o     = 1'b1;
                alu_select_o = ALU_SEL_W'(ALU_AND);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// LEGLite multicycle controller: sequences each instruction through
// FETCH/DECODE/EXEC/MEM/WB, stalls on mem_ready and counts retired instructions.
module multicycle_control
    import leglite_pkg::*;
#(
    parameter int unsigned OPCODE_W  = 3,
    parameter int unsigned ALU_SEL_W = 3,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 run,
    input  logic [OPCODE_W-1:0]  opcode,
    input  logic                 mem_ready,
    output logic                 pc_write,
    output logic                 ir_write,
    output logic                 branch,
    output logic                 memread,
    output logic                 memwrite,
    output logic                 memtoreg,
    output logic                 regdst,
    output logic                 regwrite,
    output logic                 alusrc,
    output logic [ALU_SEL_W-1:0] alu_select,
    output logic                 busy,
    output logic                 instr_done,
    output logic                 illegal,
    output logic [CNT_W-1:0]     retired
);

    ctl_state_t            state_q, state_d;
    logic [OPCODE_W-1:0]   op_q, op_d;

    instr_class_t          dec_cls;
    logic [ALU_SEL_W-1:0]  dec_alu;
    logic                  dec_alusrc;
    logic                  dec_regdst;
    logic                  dec_memtoreg;

    // Registered Moore outputs and their next values
    logic                  memread_q,  memread_d;
    logic                  memwrite_q, memwrite_d;
    logic                  branch_q,   branch_d;
    logic                  memtoreg_q, memtoreg_d;
    logic                  regdst_q,   regdst_d;
    logic                  regwrite_q, regwrite_d;
    logic                  alusrc_q,   alusrc_d;
    logic [ALU_SEL_W-1:0]  alu_q,      alu_d;
    logic                  busy_q,     busy_d;
    logic                  done_q,     done_d;
    logic                  fetch_q,    fetch_d;
    logic                  sw_mem_q,   sw_mem_d;
    logic                  illegal_q,  illegal_d;
    logic [CNT_W-1:0]      retired_q,  retired_d;

    logic                  done_pulse;
    logic                  retire_inc;
    ctl_state_t            end_state;

    control_decode #(
        .OPCODE_W  (OPCODE_W),
        .ALU_SEL_W (ALU_SEL_W)
    ) u_decode (
        .op_i         (op_d),
        .cls_o        (dec_cls),
        .alu_select_o (dec_alu),
        .alusrc_o     (dec_alusrc),
        .regdst_o     (dec_regdst),
        .memtoreg_o   (dec_memtoreg)
    );

    assign end_state = run ? FETCH : IDLE;

    // Opcode capture: op is only loaded during DECODE
    always_comb begin
        op_d = op_q;
        if (state_q == DECODE) begin
            op_d = opcode;
        end
    end

    // Next-state sequencing
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (run) state_d = FETCH;
            FETCH:  if (mem_ready) state_d = DECODE;
            DECODE: state_d = EXEC;
            EXEC: begin
                case (dec_cls)
                    CLS_R, CLS_IMM:  state_d = WB;
                    CLS_LW, CLS_SW:  state_d = MEM;
                    default:         state_d = end_state;
                endcase
            end
            MEM: begin
                if (mem_ready) begin
                    state_d = (dec_cls == CLS_LW) ? WB : end_state;
                end
            end
            WB:      state_d = end_state;
            default: state_d = IDLE;
        endcase
    end

    // Output decode for the upcoming state, registered below
    always_comb begin
        memread_d  = 1'b0;
        memwrite_d = 1'b0;
        branch_d   = 1'b0;
        memtoreg_d = 1'b0;
        regdst_d   = 1'b0;
        regwrite_d = 1'b0;
        alusrc_d   = 1'b0;
        alu_d      = '0;
        done_d     = 1'b0;
        fetch_d    = 1'b0;
        sw_mem_d   = 1'b0;
        busy_d     = (state_d != IDLE);
        illegal_d  = illegal_q;
        case (state_d)
            FETCH: begin
                memread_d = 1'b1;
                fetch_d   = 1'b1;
            end
            EXEC: begin
                if (dec_cls == CLS_ILL) begin
                    done_d    = 1'b1;
                    illegal_d = 1'b1;
                end else begin
                    alusrc_d = dec_alusrc;
                    alu_d    = dec_alu;
                    if (dec_cls == CLS_BEQ) begin
                        branch_d = 1'b1;
                        done_d   = 1'b1;
                    end
                end
            end
            MEM: begin
                if (dec_cls == CLS_LW) begin
                    memread_d = 1'b1;
                end else begin
                    memwrite_d = 1'b1;
                    sw_mem_d   = 1'b1;
                end
            end
            WB: begin
                regwrite_d = 1'b1;
                regdst_d   = dec_regdst;
                memtoreg_d = dec_memtoreg;
                done_d     = 1'b1;
            end
            default: ;
        endcase
    end

    // Completion pulse; an illegal opcode completes but is not retired
    assign done_pulse = done_q | (sw_mem_q & mem_ready);
    assign retire_inc = done_pulse & ~((state_q == EXEC) && (dec_cls == CLS_ILL));
    assign retired_d  = retire_inc ? retired_q + CNT_W'(1) : retired_q;

    // State and opcode registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    // Output, sticky-flag and counter registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            branch_q   <= 1'b0;
            memtoreg_q <= 1'b0;
            regdst_q   <= 1'b0;
            regwrite_q <= 1'b0;
            alusrc_q   <= 1'b0;
            alu_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            fetch_q    <= 1'b0;
            sw_mem_q   <= 1'b0;
            illegal_q  <= 1'b0;
            retired_q  <= '0;
        end else begin
            memread_q  <= memread_d;
            memwrite_q <= memwrite_d;
            branch_q   <= branch_d;
            memtoreg_q <= memtoreg_d;
            regdst_q   <= regdst_d;
            regwrite_q <= regwrite_d;
            alusrc_q   <= alusrc_d;
            alu_q      <= alu_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            fetch_q    <= fetch_d;
            sw_mem_q   <= sw_mem_d;
            illegal_q  <= illegal_d;
            retired_q  <= retired_d;
        end
    end

    // IR load and PC update coincide with the completing fetch read
    assign ir_write   = fetch_q & mem_ready;
    assign pc_write   = fetch_q & mem_ready;
    assign memread    = memread_q;
    assign memwrite   = memwrite_q;
    assign branch     = branch_q;
    assign memtoreg   = memtoreg_q;
    assign regdst     = regdst_q;
    assign regwrite   = regwrite_q;
    assign alusrc     = alusrc_q;
    assign alu_select = alu_q;
    assign busy       = busy_q;
    assign instr_done = done_pulse;
    assign illegal    = illegal_q;
    assign retired    = retired_q;

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multicycle control unit for the LEGLite datapath: the next generation of the single-cycle combinational control, which decoded `instr[15:13]` straight into datapath signals. It sequences each 16-bit instruction through IDLE/FETCH/DECODE/EXEC/MEM/WB states and stalls on a memory ready handshake. It also counts retired instructions. Opcode and ALU-select widths are parametrised for the wider-ISA variant, and the block sits between the instruction register and the datapath control inputs.

## Interface
- `OPCODE_W`, default 3: opcode field width; opcodes at or above 8 are illegal.
- `ALU_SEL_W`, default 3: width of `alu_select`.
- `CNT_W`, default 16: width of the retired-instruction counter.
- `clock`, input, 1 bit: sole clock; all state changes on the rising edge.
- `reset_n`, input, 1 bit: asynchronous, active-low reset.
- `run`, input, 1 bit: allows fetch of a new instruction.
- `opcode`, input, `OPCODE_W` bits: instruction register opcode field; valid from the cycle after `ir_write`.
- `mem_ready`, input, 1 bit: memory completes the current read/write this cycle.
- `pc_write`, `ir_write`, output, 1 bit each: PC update (PC+2); instruction register load.
- `branch`, `memread`, `memwrite`, `memtoreg`, `regdst`, `regwrite`, `alusrc`, output, 1 bit each: same meaning as in the single-cycle control.
- `alu_select`, output, `ALU_SEL_W` bits: encodings are ADD=0, SUB=1, SLT=2, AND=3.
- `busy`, output, 1 bit: state is not IDLE.
- `instr_done`, output, 1 bit: one-cycle pulse in the final cycle of an instruction.
- `illegal`, output, 1 bit: sticky flag for an undefined opcode.
- `retired`, output, `CNT_W` bits: count of completed instructions.

## Operation
- Opcode map:
  - add=0, sub=1, slt=2 are R-type.
  - lw=3, sw=4.
  - beq=5.
  - addi=6, andi=7.
- The opcode is latched into an internal `op` register in DECODE, so later changes on `opcode` have no effect until the next DECODE.
- Outputs are Moore, decoded from state and `op`.
- IDLE: all outputs 0. Go to FETCH when `run`=1.
- FETCH: `memread`=1. When `mem_ready`=1, assert `ir_write`=1 and `pc_write`=1 in the same cycle, then go to DECODE. Otherwise stay in FETCH.
- DECODE: all control outputs 0. Latch `op`, go to EXEC.
- EXEC, by opcode:
  - R-type: `alusrc`=0, `alu_select` = ADD/SUB/SLT for add/sub/slt; go to WB.
  - lw/sw: `alusrc`=1, ADD; go to MEM.
  - beq: `alusrc`=0, SUB, `branch`=1, `instr_done`=1; end of instruction.
  - addi: `alusrc`=1, ADD; go to WB.
  - andi: `alusrc`=1, AND; go to WB.
- MEM:
  - lw: `memread`=1, stall until `mem_ready`, then go to WB.
  - sw: `memwrite`=1, stall until `mem_ready`; assert `instr_done` in the `mem_ready` cycle; end of instruction.
- WB:
  - `regwrite`=1 in all cases.
  - `regdst`=1 for R-type, 0 for lw/addi/andi.
  - `memtoreg`=1 for lw only.
  - `instr_done`=1; end of instruction.
- End of instruction: next state is FETCH if `run`=1, else IDLE.
- `run` is only sampled in IDLE and at end of instruction; deasserting it mid-instruction does not abort the instruction.
- `retired` increments on every `instr_done` and wraps from all-ones to 0.
- Illegal opcode (`op` ≥ 8 when `OPCODE_W` > 3):
  - EXEC sets `illegal`=1 and pulses `instr_done` with all control outputs 0.
  - `retired` does not increment for it.
  - `illegal` clears only on reset.

## Timing
- Reset (asynchronous, `reset_n`=0): state=IDLE, `op`=0, `retired`=0, `illegal`=0, all outputs 0. Reset asserted mid-instruction aborts it with no partial write.
- Latency from FETCH entry to `instr_done` with `mem_ready` held at 1:
  - beq: 3 cycles.
  - R-type, addi, andi, sw: 4 cycles.
  - lw: 5 cycles.
- Each cycle with `mem_ready`=0 in FETCH or MEM adds one cycle; all outputs are held stable during the stall.
- `instr_done` is high for exactly one cycle per instruction.

## Structure
- Package `leglite_pkg` holds:
  - opcode constants `OP_ADD`…`OP_ANDI`;
  - ALU-select constants `ALU_ADD`, `ALU_SUB`, `ALU_SLT`, `ALU_AND`;
  - the state enum `ctl_state_t` (IDLE, FETCH, DECODE, EXEC, MEM, WB).
- Sub-module `control_decode`: combinational `op` → {instruction class, `alu_select`, `alusrc`, `regdst`, `memtoreg`}.
- The FSM, `op` register, counter and `illegal` flag live in the top module.

## Test plan
- Reset, then `run`=1, `opcode`=0 (add), `mem_ready`=1: FETCH→DECODE→EXEC→WB; the WB cycle shows `regdst`=1 and `regwrite`=1; `instr_done` asserts 4 cycles after FETCH entry; `retired`=1.
- lw with `mem_ready` low for 2 cycles in MEM: `memread` stays high for 3 cycles; WB shows `memtoreg`=1, `regdst`=0; latency 7 cycles.
- beq: EXEC shows `branch`=1, `alu_select`=1, `alusrc`=0; `instr_done` 3 cycles after FETCH entry; no `regwrite` at any point.
- sw, then `run`=0 at end of instruction: `memwrite` asserts for 1 cycle, then state goes to IDLE and all outputs are 0.
- `CNT_W`=4, run 17 addi instructions: `retired` wraps to 1. `OPCODE_W`=4 with `opcode`=9: `illegal`=1, `retired` unchanged.
- Assert `reset_n`=0 in the cycle lw enters MEM: outputs go to 0 immediately; after release the block sits in IDLE.
